// File: rtl/fir_sched_pkg.sv
// Shared constants, datapath types and FSM encoding for the time-shared FIR MAC scheduler.
package fir_sched_pkg;

    localparam int TAPS = 64;
    localparam int SW   = 16;
    localparam int WW   = 10;
    localparam int AW   = 32;

    typedef logic signed [SW-1:0] sample_t;
    typedef logic signed [WW-1:0] weight_t;
    typedef logic signed [AW-1:0] acc_t;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MAC  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        MAC  = ST_MAC,
        DONE = ST_DONE
    } state_t;

endpackage

// File: rtl/fir_ring_buffer.sv
// Per-channel circular sample store with a one-deep hold register for samples that
// arrive while the channel is being filtered, plus pending and sticky overrun flags.
module fir_ring_buffer #(
    parameter int TAPS = fir_sched_pkg::TAPS,
    parameter int SW   = fir_sched_pkg::SW,
    localparam int IW  = $clog2(TAPS)
) (
    input  logic          clk_in,
    input  logic          rst_in,
    input  logic          wr_valid_in,
    input  logic [SW-1:0] wr_data_in,
    input  logic          busy_in,
    input  logic          commit_in,
    input  logic          grant_in,
    input  logic [IW-1:0] rd_idx_in,
    output logic [SW-1:0] rd_data_out,
    output logic [IW-1:0] wptr_out,
    output logic          pending_out,
    output logic          overrun_out
);
    import fir_sched_pkg::*;

    logic [SW-1:0] ring_q [TAPS];
    logic [IW-1:0] wptr_q, wptr_d;
    logic [SW-1:0] hold_q, hold_d;
    logic          hold_full_q, hold_full_d;
    logic          pending_q, pending_d;
    logic          overrun_q, overrun_d;
    logic          wr_en;
    logic [SW-1:0] wr_data;

    // NOTE: every signal gets a default at the top of always_comb so no path leaves it unassigned (no latch).
    always_comb begin
        wr_en       = 1'b0;
        wr_data     = wr_data_in;
        wptr_d      = wptr_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        pending_d   = pending_q;
        overrun_d   = overrun_q;

        if (grant_in) begin
            pending_d = 1'b0;
        end

        // Commit only happens in DONE, when the channel is busy, so it never collides with a direct write.
        if (commit_in && hold_full_q) begin
            wr_en       = 1'b1;
            wr_data     = hold_q;
            hold_full_d = 1'b0;
        end

        if (wr_valid_in) begin
            if (!busy_in) begin
                wr_en   = 1'b1;
                wr_data = wr_data_in;
            end else if (hold_full_q) begin
                overrun_d = 1'b1;
            end else begin
                hold_d      = wr_data_in;
                hold_full_d = 1'b1;
            end
        end

        if (wr_en) begin
            wptr_d    = wptr_q + IW'(1);
            pending_d = 1'b1;
        end
    end

    // NOTE: the ring is a flop array, not a RAM, because old taps must read as zero after reset.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < TAPS; i++) begin
                ring_q[i] <= '0;
            end
        end else if (wr_en) begin
            ring_q[wptr_q] <= wr_data;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            wptr_q      <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            pending_q   <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            pending_q   <= pending_d;
            overrun_q   <= overrun_d;
        end
    end

    assign rd_data_out = ring_q[rd_idx_in];
    assign wptr_out    = wptr_q;
    assign pending_out = pending_q;
    assign overrun_out = overrun_q;

endmodule

// File: rtl/fir_mac_scheduler.sv
// Time-shared FIR: a round-robin arbiter picks a channel with a new sample, runs TAPS
// MAC cycles over that channel's ring, and emits the result tagged with its channel.
module fir_mac_scheduler #(
    parameter int N_CH = 2,
    parameter int TAPS = fir_sched_pkg::TAPS,
    parameter int SW   = fir_sched_pkg::SW,
    parameter int WW   = fir_sched_pkg::WW,
    parameter int AW   = fir_sched_pkg::AW,
    localparam int CHW = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic [N_CH-1:0]         sample_valid_in,
    input  logic [N_CH-1:0][SW-1:0] sample_in,
    input  logic [TAPS-1:0][WW-1:0] weights_in,
    output logic [AW-1:0]           signal_out,
    output logic                    out_valid,
    output logic [CHW-1:0]          out_ch,
    output logic                    busy_out,
    output logic [N_CH-1:0]         overrun_out
);
    import fir_sched_pkg::*;

    localparam int IW = $clog2(TAPS);
    localparam int PW = SW + WW;

    state_t                state_q, state_d;
    logic [CHW-1:0]        act_ch_q, act_ch_d;
    logic [CHW-1:0]        last_grant_q, last_grant_d;
    logic [CHW-1:0]        out_ch_q, out_ch_d;
    logic [IW-1:0]         base_q, base_d;
    logic [IW-1:0]         index_q, index_d;
    logic signed [AW-1:0]  acc_q, acc_d;
    logic signed [AW-1:0]  signal_q, signal_d;
    logic                  out_valid_q, out_valid_d;

    logic                  grant_valid;
    logic [CHW-1:0]        grant_ch;
    logic [CHW-1:0]        cand_ch;
    logic [IW-1:0]         rd_idx;
    logic [SW-1:0]         rd_data [N_CH];
    logic [IW-1:0]         wptr    [N_CH];
    logic [N_CH-1:0]       pending, ch_busy, ch_grant, ch_commit;
    logic signed [SW-1:0]  cur_sample;
    logic signed [WW-1:0]  cur_weight;
    logic signed [PW-1:0]  product;

    // Round-robin: first pending channel strictly after last_grant, wrapping.
    always_comb begin
        grant_valid = 1'b0;
        grant_ch    = '0;
        cand_ch     = '0;
        if (state_q == IDLE) begin
            for (int i = 1; i <= N_CH; i++) begin
                cand_ch = CHW'((int'(last_grant_q) + i) % N_CH);
                if (!grant_valid && pending[cand_ch]) begin
                    grant_valid = 1'b1;
                    grant_ch    = cand_ch;
                end
            end
        end
    end

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        assign ch_grant[c]  = grant_valid && (grant_ch == CHW'(c));
        assign ch_commit[c] = (state_q == DONE) && (act_ch_q == CHW'(c));
        assign ch_busy[c]   = ch_grant[c] || ((state_q != IDLE) && (act_ch_q == CHW'(c)));

        fir_ring_buffer #(
            .TAPS (TAPS),
            .SW   (SW)
        ) u_ring (
            .clk_in      (clk_in),
            .rst_in      (rst_in),
            .wr_valid_in (sample_valid_in[c]),
            .wr_data_in  (sample_in[c]),
            .busy_in     (ch_busy[c]),
            .commit_in   (ch_commit[c]),
            .grant_in    (ch_grant[c]),
            .rd_idx_in   (rd_idx),
            .rd_data_out (rd_data[c]),
            .wptr_out    (wptr[c]),
            .pending_out (pending[c]),
            .overrun_out (overrun_out[c])
        );
    end

    // base is the newest sample; walking backwards through the ring ages the tap.
    assign rd_idx = base_q - index_q;

    always_comb begin
        cur_sample = rd_data[act_ch_q];
        cur_weight = weights_in[index_q];
        product    = PW'(cur_weight) * PW'(cur_sample);
    end

    always_comb begin
        state_d      = state_q;
        act_ch_d     = act_ch_q;
        last_grant_d = last_grant_q;
        base_d       = base_q;
        index_d      = index_q;
        acc_d        = acc_q;
        signal_d     = signal_q;
        out_valid_d  = 1'b0;
        out_ch_d     = out_ch_q;

        case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    act_ch_d     = grant_ch;
                    last_grant_d = grant_ch;
                    base_d       = wptr[grant_ch] - IW'(1);
                    index_d      = '0;
                    acc_d        = '0;
                    state_d      = MAC;
                end
            end
            MAC: begin
                acc_d   = acc_q + AW'(product);
                index_d = index_q + IW'(1);
                // Result registers load on the last tap so they are valid during DONE.
                if (index_q == IW'(TAPS - 1)) begin
                    state_d     = DONE;
                    signal_d    = acc_d;
                    out_valid_d = 1'b1;
                    out_ch_d    = act_ch_q;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q      <= IDLE;
            act_ch_q     <= '0;
            last_grant_q <= CHW'(N_CH - 1);
            base_q       <= '0;
            index_q      <= '0;
            acc_q        <= '0;
            signal_q     <= '0;
            out_valid_q  <= 1'b0;
            out_ch_q     <= '0;
        end else begin
            state_q      <= state_d;
            act_ch_q     <= act_ch_d;
            last_grant_q <= last_grant_d;
            base_q       <= base_d;
            index_q      <= index_d;
            acc_q        <= acc_d;
            signal_q     <= signal_d;
            out_valid_q  <= out_valid_d;
            out_ch_q     <= out_ch_d;
        end
    end

    assign signal_out = signal_q;
    assign out_valid  = out_valid_q;
    assign out_ch     = out_ch_q;
    assign busy_out   = (state_q != IDLE);

endmodule

// File: tb/tb_fir_mac_scheduler.sv
// Directed bench for fir_mac_scheduler: table of strobe vectors with hand-computed
// results, then hand-written overrun, worst-case and mid-operation reset sequences.
module tb_fir_mac_scheduler;
    import fir_sched_pkg::*;

    logic                  clk_in = 1'b0;
    logic                  rst_in;
    logic [1:0]            sample_valid_in;
    logic [1:0][SW-1:0]    sample_in;
    logic [TAPS-1:0][WW-1:0] weights_in;
    acc_t                  signal_out;
    logic                  out_valid;
    logic [0:0]            out_ch;
    logic                  busy_out;
    logic [1:0]            overrun_out;

    fir_mac_scheduler #(.N_CH(2)) dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .sample_valid_in (sample_valid_in),
        .sample_in       (sample_in),
        .weights_in      (weights_in),
        .signal_out      (signal_out),
        .out_valid       (out_valid),
        .out_ch          (out_ch),
        .busy_out        (busy_out),
        .overrun_out     (overrun_out)
    );

    always #5 clk_in = ~clk_in;

    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    typedef struct {
        int   t;
        acc_t val;
        logic ch;
    } res_t;
    res_t res_q[$];

    always @(negedge clk_in) begin
        if (out_valid === 1'b1) res_q.push_back('{cyc, signal_out, out_ch[0]});
    end

    typedef struct {
        logic [1:0] vld;
        sample_t    s0;
        sample_t    s1;
        int         n_res;
        acc_t       e0;
        logic       e0_ch;
        acc_t       e1;
        logic       e1_ch;
    } vec_t;
    vec_t tv [8];

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic signed [63:0] act,
                         input logic signed [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_res(input string name, input int idx, input int exp_t,
                             input acc_t exp_val, input logic exp_ch);
        if (idx < res_q.size()) begin
            check($sformatf("%s_lat", name), res_q[idx].t, exp_t);
            check($sformatf("%s_val", name), res_q[idx].val, exp_val);
            check($sformatf("%s_ch", name), res_q[idx].ch, exp_ch);
        end
    endtask

    task automatic check_quiet_outputs(input string tag);
        check($sformatf("%s_signal", tag), signal_out, 0);
        check($sformatf("%s_valid", tag), out_valid, 0);
        check($sformatf("%s_ch", tag), out_ch, 0);
        check($sformatf("%s_busy", tag), busy_out, 0);
        check($sformatf("%s_ovr", tag), overrun_out, 0);
    endtask

    task automatic strobe(input logic [1:0] vld, input sample_t s0, input sample_t s1);
        sample_valid_in = vld;
        sample_in[0]    = s0;
        sample_in[1]    = s1;
        @(negedge clk_in);
        sample_valid_in = '0;
    endtask

    task automatic wait_to(input int target);
        while (cyc < target) @(negedge clk_in);
    endtask

    task automatic pulse_reset();
        rst_in = 1'b1;
        @(negedge clk_in);
        rst_in = 1'b0;
    endtask

    int t0, t_first, t_last;

    initial begin
        // Weights k+1; ring contents expressed newest-first when computing expectations.
        tv[0] = '{2'b11, 16'sd100,  16'sd7,    2, 32'sd100,  1'b0, 32'sd7,   1'b1};
        tv[1] = '{2'b11, 16'sd0,    16'sd2,    2, 32'sd200,  1'b0, 32'sd16,  1'b1};
        tv[2] = '{2'b01, 16'sd0,    16'sd0,    1, 32'sd300,  1'b0, 32'sd0,   1'b0};
        tv[3] = '{2'b01, 16'sd0,    16'sd0,    1, 32'sd400,  1'b0, 32'sd0,   1'b0};
        tv[4] = '{2'b10, 16'sd0,    16'sd1000, 1, 32'sd1025, 1'b1, 32'sd0,   1'b0};
        tv[5] = '{2'b01, -16'sd3,   16'sd0,    1, 32'sd497,  1'b0, 32'sd0,   1'b0};
        tv[6] = '{2'b11, 16'sd0,    -16'sd1,   2, 32'sd2033, 1'b1, 32'sd594, 1'b0};
        tv[7] = '{2'b01, 16'sd0,    16'sd0,    1, 32'sd691,  1'b0, 32'sd0,   1'b0};

        rst_in          = 1'b1;
        sample_valid_in = '0;
        sample_in       = '0;
        for (int k = 0; k < TAPS; k++) weights_in[k] = WW'(k + 1);
        repeat (3) @(negedge clk_in);
        rst_in = 1'b0;
        @(negedge clk_in);
        check_quiet_outputs("reset");

        // Table: impulse response, simultaneous strobes and round-robin order.
        for (int i = 0; i < 8; i++) begin
            res_q.delete();
            t0 = cyc;
            strobe(tv[i].vld, tv[i].s0, tv[i].s1);
            wait_to(t0 + 140);
            check($sformatf("v%0d_count", i), res_q.size(), tv[i].n_res);
            check_res($sformatf("v%0d_r0", i), 0, t0 + 66, tv[i].e0, tv[i].e0_ch);
            if (tv[i].n_res > 1)
                check_res($sformatf("v%0d_r1", i), 1, t0 + 132, tv[i].e1, tv[i].e1_ch);
        end

        // ch1 gets two samples while ch0 computes: both land in ring1, one ch1 result on newest data.
        res_q.delete();
        t0 = cyc;
        strobe(2'b01, 16'sd10, 16'sd0);
        wait_to(t0 + 10);
        strobe(2'b10, 16'sd0, 16'sd50);
        wait_to(t0 + 20);
        strobe(2'b10, 16'sd0, 16'sd60);
        wait_to(t0 + 200);
        check("newest_count", res_q.size(), 2);
        check_res("newest_r0", 0, t0 + 66, 32'sd798, 1'b0);
        check_res("newest_r1", 1, t0 + 132, 32'sd4209, 1'b1);

        // Overrun: first in-flight ch0 sample held and committed, second dropped.
        res_q.delete();
        t0 = cyc;
        strobe(2'b01, 16'sd1, 16'sd0);
        wait_to(t0 + 10);
        strobe(2'b01, 16'sd2, 16'sd0);
        wait_to(t0 + 20);
        strobe(2'b01, 16'sd4, 16'sd0);
        wait_to(t0 + 25);
        check("ovr_flag_set", overrun_out, 2'b01);
        check("ovr_busy", busy_out, 1);
        wait_to(t0 + 200);
        check("ovr_count", res_q.size(), 2);
        check_res("ovr_r0", 0, t0 + 66, 32'sd906, 1'b0);
        check_res("ovr_r1", 1, t0 + 132, 32'sd1016, 1'b0);
        check("ovr_flag_sticky", overrun_out, 2'b01);

        // Worst case magnitude: 64 x (-512 * -32768).
        pulse_reset();
        check("wc_ovr_cleared", overrun_out, 2'b00);
        for (int k = 0; k < TAPS; k++) weights_in[k] = 10'h200;
        res_q.delete();
        t_first = cyc;
        t_last  = cyc;
        for (int n = 0; n < TAPS; n++) begin
            t_last = cyc;
            strobe(2'b01, -16'sd32768, 16'sd0);
            wait_to(t_last + 70);
        end
        check("wc_count", res_q.size(), 64);
        check_res("wc_first", 0, t_first + 66, 32'sd16777216, 1'b0);
        check_res("wc_last", 63, t_last + 66, 32'sd1073741824, 1'b0);
        repeat (10) @(negedge clk_in);
        check("wc_hold", signal_out, 32'sd1073741824);

        // Reset 30 cycles into MAC: no result, outputs cleared, rings cleared.
        weights_in[0] = 10'd3;
        for (int k = 1; k < TAPS; k++) weights_in[k] = WW'(k + 1);
        res_q.delete();
        t0 = cyc;
        strobe(2'b01, 16'sd9, 16'sd0);
        wait_to(t0 + 31);
        pulse_reset();
        check_quiet_outputs("midrst");
        wait_to(t0 + 120);
        check("midrst_no_result", res_q.size(), 0);
        res_q.delete();
        t0 = cyc;
        strobe(2'b01, 16'sd5, 16'sd0);
        wait_to(t0 + 80);
        check("post_rst_count", res_q.size(), 1);
        check_res("post_rst", 0, t0 + 66, 32'sd15, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fir_mac_scheduler.md
Name: fir_mac_scheduler

Overview:
- Shares one 64-tap multiply-accumulate engine between N_CH sample streams, e.g. left and right mic channels.
- Each channel owns a 64-deep circular sample buffer. The shared weight set is applied to every channel.
- A round-robin arbiter grants the engine to a channel with a new sample and sequences the 64 MAC cycles. It then emits the filtered result tagged with its channel.
- Sits between the per-channel sample sources (decimated audio) and downstream mixing/anti-noise logic.

Parameters:
- N_CH, 2, number of input channels (1..4)
- TAPS, 64, filter length and ring depth (power of two)
- SW, 16, signed sample width
- WW, 10, signed weight width
- AW, 32, accumulator and output width

Ports:
- clk_in  in  1  system clock
- rst_in  in  1  reset
- sample_valid_in  in  N_CH  one-cycle strobe per channel
- sample_in  in  N_CH x SW  signed samples, sampled when the matching strobe is high
- weights_in  in  TAPS x WW  signed coefficients; weights_in[k] multiplies the sample k steps old; must be static while busy_out is high
- signal_out  out  AW  signed filter result
- out_valid  out  1  one-cycle strobe; signal_out and out_ch are valid
- out_ch  out  $clog2(N_CH) (min 1)  channel of the current result
- busy_out  out  1  high when state is not IDLE
- overrun_out  out  N_CH  sticky sample-drop flags

Behaviour:
- Clock is clk_in. Reset is rst_in, synchronous and active-high.
- On reset, all of the following clear to 0:
  - signal_out, out_valid, out_ch, busy_out, overrun_out
  - all ring contents, write pointers, pending flags and hold registers
- On reset, last_grant = N_CH-1, so channel 0 wins first.
- Reset mid-computation aborts the computation with no out_valid.
- Ring write, idle channel: when sample_valid_in[c] is high, the sample is written at wptr[c], wptr[c] increments mod TAPS, and pending[c] is set. pending[c] is visible the next cycle.
- Ring write, busy channel: channel c is busy if it is active in MAC/DONE or is being granted this cycle.
  - A sample for a busy channel goes into hold[c] instead of the ring.
  - If hold[c] is already full, the sample is dropped and overrun_out[c] is set (sticky until reset).
- States are IDLE, MAC and DONE.
- IDLE:
  - If any pending flag is set, grant the first pending channel after last_grant in ascending wrap order.
  - On grant, latch act_ch, base = wptr[act_ch]-1, index = 0, acc = 0.
  - Clear pending[act_ch] and update last_grant.
  - Go to MAC.
- MAC:
  - Each cycle: acc += weights_in[index] * ring[act_ch][(base-index) mod TAPS]. Product is full width SW+WW, sign-extended to AW.
  - index increments.
  - After the index = TAPS-1 cycle, go to DONE.
  - Exactly TAPS MAC cycles; no wrap or overflow handling needed (AW holds the worst case).
- DONE:
  - signal_out <= acc, out_ch <= act_ch, out_valid high for this single cycle.
  - If hold[act_ch] is full, write it to the ring, advance wptr, set pending[act_ch] and clear hold.
  - Go to IDLE.
- signal_out holds its value until the next DONE.
- Latency: a sample strobe at cycle T to an idle engine with nothing else pending gives out_valid at T+66.
  - T+1: grant
  - T+2..T+65: MAC
  - T+66: DONE
- Back-to-back throughput: one result per TAPS+2 cycles.
- Simultaneous events:
  - Strobes on several channels in the same cycle are all accepted.
  - A strobe on a non-active channel during MAC goes straight to its ring.
  - A pending channel that receives another sample before being granted still produces one result, computed on the newest data.

Decomposition:
- Package fir_sched_pkg:
  - TAPS, SW, WW, AW constants
  - sample_t, weight_t, acc_t typedefs
  - state_t enum {IDLE, MAC, DONE}
- Sub-module fir_ring_buffer, instantiated once per channel:
  - ring storage, wptr, hold register, pending and overrun flags
  - combinational read port at an index
- Arbiter, FSM and MAC stay in the top.

Test Plan:
- Impulse response:
  - Setup: weights_in[k] = k+1, reset.
  - Stimulus: ch0 sample 100 at T, then ch0 samples 0 spaced 70 cycles apart.
  - Required: out_valid at T+66 with signal_out = 100 and out_ch = 0; next results 200, 300, ...
- Arbitration:
  - Stimulus: ch0 and ch1 strobe together at T.
  - Required: ch0 result at T+66, ch1 result at T+132; next simultaneous pair is served ch0 then ch1 again (round-robin).
- Overrun:
  - Stimulus: two ch0 strobes during ch0 MAC.
  - Required: first sample held and committed at DONE, then one more ch0 result follows; second sample dropped; overrun_out[0] = 1 and stays 1; overrun_out[1] = 0.
- Worst-case magnitude:
  - Stimulus: all weights -512, 64 samples of -32768.
  - Required: signal_out = 1073741824, no overflow.
- Reset mid-operation:
  - Stimulus: rst_in pulsed at cycle 30 of MAC.
  - Required: no out_valid; all outputs 0; a later impulse of 5 with weights_in[0] = 3 gives exactly 15, since the rings were cleared.
